// File: rtl/mash_ncnet_pipe_if.sv
// Sample-side bus of the MASH noise-cancelling network: per-sample strobes,
// order select and carry vector in, combined signed output and valid out.
interface mash_ncnet_pipe_if #(
  parameter int P_STAGES    = 3,
  parameter int P_OUT_WIDTH = 4
);
  localparam int P_ORD_W = $clog2(P_STAGES + 1);

  logic                          i_en;
  logic                          i_clr;
  logic [P_ORD_W-1:0]            i_order;
  logic [P_STAGES-1:0]           i_carry;
  logic signed [P_OUT_WIDTH-1:0] o_y;
  logic                          o_valid;

  modport master (
    output i_en, i_clr, i_order, i_carry,
    input  o_y, o_valid
  );

  modport slave (
    input  i_en, i_clr, i_order, i_carry,
    output o_y, o_valid
  );
endinterface

// File: rtl/mash_ncnet_pipe.sv
// Registered MASH noise-cancelling network: y = sum_k (1-z^-1)^(k-1) * c_k
// over P_STAGES accumulator carries, with runtime order select. The network
// is evaluated as a nested chain t_k = c_k + t_(k+1) - t_(k+1)[n-1], so each
// stage needs one difference register holding last sample's t_(k+1).
module mash_ncnet_pipe #(
  parameter int P_STAGES    = 3,
  parameter int P_OUT_WIDTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  mash_ncnet_pipe_if.slave  bus
);

  localparam int P_ORD_W = $clog2(P_STAGES + 1);
  // diff_q[j] holds the previous t of stage j+2; at least one entry so that
  // a single-stage build still elaborates.
  localparam int P_ND    = (P_STAGES > 1) ? P_STAGES - 1 : 1;

  generate
    if (P_STAGES < 1 || P_STAGES > 6) begin : g_bad_stages
      $error("mash_ncnet_pipe: P_STAGES must be in 1..6");
    end
    if (P_OUT_WIDTH < P_STAGES + 1) begin : g_bad_width
      $error("mash_ncnet_pipe: P_OUT_WIDTH must be >= P_STAGES+1");
    end
  endgenerate

  logic [P_ORD_W-1:0]            order_eff;
  logic [P_STAGES-1:0]           carry_m;
  logic signed [P_OUT_WIDTH-1:0] t [P_STAGES];

  logic signed [P_OUT_WIDTH-1:0] diff_q [P_ND];
  logic signed [P_OUT_WIDTH-1:0] diff_d [P_ND];
  logic signed [P_OUT_WIDTH-1:0] y_q, y_d;
  logic                          valid_q, valid_d;

  // Clamp the requested order into 1..P_STAGES and mask carries above it.
  // Masked stages then feed zeros into their difference registers, so a
  // lower order takes effect without flushing.
  always_comb begin
    order_eff = bus.i_order;
    if (bus.i_order == '0) begin
      order_eff = P_ORD_W'(1);
    end else if (int'(bus.i_order) > P_STAGES) begin
      order_eff = P_ORD_W'(P_STAGES);
    end
    carry_m = '0;
    for (int k = 0; k < P_STAGES; k++) begin
      carry_m[k] = (k < int'(order_eff)) ? bus.i_carry[k] : 1'b0;
    end
  end

  // Nested differencing chain from the last stage down to the first.
  always_comb begin
    for (int k = 0; k < P_STAGES; k++) begin
      t[k] = '0;
    end
    t[P_STAGES-1] = {{(P_OUT_WIDTH-1){1'b0}}, carry_m[P_STAGES-1]};
    for (int k = P_STAGES - 2; k >= 0; k--) begin
      t[k] = {{(P_OUT_WIDTH-1){1'b0}}, carry_m[k]} + t[k+1] - diff_q[k];
    end
  end

  // Next state: clear beats enable; an enabled sample captures the chain.
  always_comb begin
    diff_d  = diff_q;
    y_d     = y_q;
    valid_d = 1'b0;
    if (bus.i_clr) begin
      for (int j = 0; j < P_ND; j++) begin
        diff_d[j] = '0;
      end
      y_d = '0;
    end else if (bus.i_en) begin
      for (int j = 0; j < P_STAGES - 1; j++) begin
        diff_d[j] = t[j+1];
      end
      y_d     = t[0];
      valid_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int j = 0; j < P_ND; j++) begin
        diff_q[j] <= '0;
      end
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      diff_q  <= diff_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_y     = y_q;
  assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_mash_ncnet_pipe.sv
// Bench for mash_ncnet_pipe: three builds (3/4, 4/5, 2/3). The reference keeps
// the masked carry history of every stage and evaluates the binomial
// expansion of (1-z^-1)^(k-1) directly.
module tb_mash_ncnet_pipe;

  localparam int NI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mash_ncnet_pipe_if #(.P_STAGES(3), .P_OUT_WIDTH(4)) if3 ();
  mash_ncnet_pipe_if #(.P_STAGES(4), .P_OUT_WIDTH(5)) if4 ();
  mash_ncnet_pipe_if #(.P_STAGES(2), .P_OUT_WIDTH(3)) if2 ();

  mash_ncnet_pipe #(.P_STAGES(3), .P_OUT_WIDTH(4)) u_dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));
  mash_ncnet_pipe #(.P_STAGES(4), .P_OUT_WIDTH(5)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));
  mash_ncnet_pipe #(.P_STAGES(2), .P_OUT_WIDTH(3)) u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));

  logic en_v  [NI];
  logic clr_v [NI];
  int   ord_v [NI];
  int   car_v [NI];
  int   y_obs [NI];
  logic v_obs [NI];

  assign if3.i_en = en_v[0];  assign if3.i_clr = clr_v[0];
  assign if4.i_en = en_v[1];  assign if4.i_clr = clr_v[1];
  assign if2.i_en = en_v[2];  assign if2.i_clr = clr_v[2];
  assign if3.i_order = ord_v[0][1:0];  assign if3.i_carry = car_v[0][2:0];
  assign if4.i_order = ord_v[1][2:0];  assign if4.i_carry = car_v[1][3:0];
  assign if2.i_order = ord_v[2][1:0];  assign if2.i_carry = car_v[2][1:0];
  assign y_obs[0] = int'(if3.o_y);  assign v_obs[0] = if3.o_valid;
  assign y_obs[1] = int'(if4.o_y);  assign v_obs[1] = if4.o_valid;
  assign y_obs[2] = int'(if2.o_y);  assign v_obs[2] = if2.o_valid;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int p_of(input int i);
    return (i == 0) ? 3 : (i == 1) ? 4 : 2;
  endfunction

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int m = 0; m < k; m++) r = r * (n - m) / (m + 1);
    return r;
  endfunction

  // Reference state: hist[inst][stage][lag], lag 0 = current sample.
  int hist   [NI][6][6];
  int exp_y  [NI];
  int exp_v  [NI];
  int last_n [NI];
  int stable [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 6; k++)
        for (int j = 0; j < 6; j++) hist[i][k][j] = 0;
      exp_y[i] = 0;
      exp_v[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int p, n, y;
    p = p_of(i);
    if (clr_v[i]) begin
      for (int k = 0; k < 6; k++)
        for (int j = 0; j < 6; j++) hist[i][k][j] = 0;
      exp_y[i] = 0;
      exp_v[i] = 0;
    end else if (en_v[i]) begin
      n = ord_v[i];
      if (n == 0) n = 1;
      if (n > p) n = p;
      for (int k = 0; k < 6; k++) begin
        for (int j = 5; j > 0; j--) hist[i][k][j] = hist[i][k][j-1];
        hist[i][k][0] = (k < p && k < n) ? ((car_v[i] >> k) & 1) : 0;
      end
      y = 0;
      for (int k = 0; k < p; k++)
        for (int j = 0; j <= k; j++)
          y += (((j % 2) == 1) ? -1 : 1) * binom(k, j) * hist[i][k][j];
      exp_y[i] = y;
      exp_v[i] = 1;
      if (n == last_n[i]) stable[i]++;
      else begin
        stable[i] = 1;
        last_n[i] = n;
      end
    end else begin
      exp_v[i] = 0;
    end
  endtask

  task automatic tick();
    int p, hi, lo;
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
    for (int i = 0; i < NI; i++) begin
      p = p_of(i);
      chk($sformatf("y_p%0d", p), y_obs[i], exp_y[i]);
      chk($sformatf("valid_p%0d", p), int'(v_obs[i]), exp_v[i]);
      if (en_v[i] && !clr_v[i] && stable[i] >= p) begin
        hi = 1 << (last_n[i] - 1);
        lo = -(hi - 1);
        chk($sformatf("range_p%0d", p), (y_obs[i] >= lo && y_obs[i] <= hi) ? 1 : 0, 1);
      end
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < NI; i++) begin
      en_v[i]  = 1'b0;
      clr_v[i] = 1'b0;
    end
  endtask

  task automatic s3(input logic en, input logic clr, input int ord, input int car);
    idle_all();
    en_v[0]  = en;
    clr_v[0] = clr;
    ord_v[0] = ord;
    car_v[0] = car;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      en_v[i] = 1'b0; clr_v[i] = 1'b0; ord_v[i] = p_of(i); car_v[i] = 0;
      last_n[i] = 0; stable[i] = 0;
    end
    model_reset();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("por_y", y_obs[0], 0);
    chk("por_valid", int'(v_obs[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All carries high, order 3
    s3(1, 0, 3, 7); chk("ones_s1", y_obs[0], 3); chk("ones_v1", int'(v_obs[0]), 1);
    s3(1, 0, 3, 7); chk("ones_s2", y_obs[0], 0);
    s3(1, 0, 3, 7); chk("ones_s3", y_obs[0], 1);
    s3(1, 0, 3, 7); chk("ones_s4", y_obs[0], 1);

    // Asynchronous reset in the middle of a cycle while enabled
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", y_obs[0], 0);
    chk("async_rst_valid", int'(v_obs[0]), 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    s3(1, 0, 3, 7); chk("post_rst_y", y_obs[0], 3);

    // Extremes at order 3
    s3(0, 1, 3, 0);
    s3(1, 0, 3, 4); s3(1, 0, 3, 0); s3(1, 0, 3, 7);
    chk("max_y", y_obs[0], 4);
    s3(0, 1, 3, 0);
    s3(1, 0, 3, 0); s3(1, 0, 3, 6); s3(1, 0, 3, 0);
    chk("min_y", y_obs[0], -3);

    // Order clamping and mid-stream order changes
    s3(0, 1, 3, 0);
    s3(1, 0, 1, 6); chk("ord1_y", y_obs[0], 0);
    s3(1, 0, 0, 7); chk("ord0_y", y_obs[0], 1);
    s3(1, 0, 3, 5); s3(1, 0, 1, 3); s3(1, 0, 1, 2);
    s3(1, 0, 3, 7); s3(1, 0, 3, 1); s3(1, 0, 3, 6);
    idle_all(); clr_v[1] = 1'b1; tick();
    idle_all(); en_v[1] = 1'b1; ord_v[1] = 7; car_v[1] = 15; tick();
    chk("ord7_clamp_y", y_obs[1], 4);

    // Enable gaps and clear
    s3(0, 1, 3, 0);
    s3(1, 0, 3, 7); chk("gap_s1", y_obs[0], 3);
    s3(0, 0, 3, 7); chk("gap_hold1", y_obs[0], 3); chk("gap_v1", int'(v_obs[0]), 0);
    s3(0, 0, 3, 7); chk("gap_hold2", y_obs[0], 3);
    s3(1, 0, 3, 7); chk("gap_s2", y_obs[0], 0);
    s3(1, 1, 3, 7); chk("clr_y", y_obs[0], 0); chk("clr_v", int'(v_obs[0]), 0);
    s3(1, 0, 3, 7); chk("after_clr_y", y_obs[0], 3);

    // Randomised run on the 4-stage and 2-stage builds
    idle_all();
    for (int n = 0; n < 10000; n++) begin
      for (int i = 1; i < NI; i++) begin
        en_v[i]  = ($urandom % 5) != 0;
        clr_v[i] = ($urandom % 64) == 0;
        if (($urandom % 40) == 0)
          ord_v[i] = $urandom_range(0, (i == 1) ? 7 : 3);
        car_v[i] = $urandom & ((1 << p_of(i)) - 1);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
